clk_btn_conditioner: RTL and testbench

Front-end stage that feeds the clock/alarm top level. It runs from the board's fast system clock and does three things:
- derives the ~1 Hz Pulse square wave that the time/alarm counters use as their clock;
- synchronizes and debounces the six manual switches (Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon), presenting them as clean levels;
- provides one-cycle rising-edge strobes for the same switches.

---
 rtl/clk_btn_conditioner.sv | 142 ++++++++++++++
 tb/tb_clk_btn_conditioner.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_btn_conditioner.sv
// Clock/alarm front end: Pulse divider, switch synchronizer/debouncer and rise strobes.
// Optional fast-set mode is enabled by defining FAST_SET_EN.
module clk_btn_conditioner #(
    parameter int DIV    = 50000000,
    parameter int DB_CYC = 500000,
    parameter int NB     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NB-1:0] btn_raw,
    output logic [NB-1:0] btn_clean,
    output logic [NB-1:0] btn_rise,
    output logic          pulse,
    output logic          tick,
    output logic          fast
);

    localparam int CW = $clog2(DB_CYC + 1);
    localparam int DW = $clog2(DIV);

    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [CW-1:0] db_cnt     [NB];
    logic [CW-1:0] db_cnt_nxt [NB];
    logic [NB-1:0] clean_nxt;
    logic [NB-1:0] rise_nxt;

    logic [DW-1:0] dc;
    logic [DW-1:0] dc_nxt;
    logic [DW-1:0] dc_last;
    logic [DW-1:0] dc_half;
    logic          restart;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A bit only changes after DB_CYC consecutive cycles disagreeing with btn_clean.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            db_cnt_nxt[i] = '0;
            clean_nxt[i]  = btn_clean[i];
            rise_nxt[i]   = 1'b0;
            if (sync2[i] != btn_clean[i]) begin
                if (db_cnt[i] == CW'(DB_CYC - 1)) begin
                    clean_nxt[i] = sync2[i];
                    rise_nxt[i]  = sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
            btn_clean <= '0;
            btn_rise  <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
            btn_clean <= clean_nxt;
            btn_rise  <= rise_nxt;
        end
    end

`ifdef FAST_SET_EN
    logic       set_now;
    logic       set_nxt;
    logic       enter;
    logic       leave;
    logic       fast_q;
    logic [1:0] hold_cnt;

    // set_nxt looks at the next debounced levels so fast mode drops in the same cycle the switch does.
    always_comb begin
        set_now = (btn_clean[0] | btn_clean[1]) & (btn_clean[2] | btn_clean[3] | btn_clean[4]);
        set_nxt = (clean_nxt[0] | clean_nxt[1]) & (clean_nxt[2] | clean_nxt[3] | clean_nxt[4]);
        enter   = !fast_q && tick && set_now && set_nxt && (hold_cnt == 2'd1);
        leave   = fast_q && !set_nxt;
        restart = enter || leave;
        dc_last = fast_q ? DW'(DIV / 8 - 1) : DW'(DIV - 1);
        dc_half = fast_q ? DW'(DIV / 16) : DW'(DIV / 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            fast_q   <= 1'b0;
        end else begin
            if (!set_nxt) begin
                hold_cnt <= '0;
            end else if (tick && set_now && hold_cnt != 2'd2) begin
                hold_cnt <= hold_cnt + 2'd1;
            end
            if (enter) begin
                fast_q <= 1'b1;
            end else if (leave) begin
                fast_q <= 1'b0;
            end
        end
    end

    assign fast = fast_q;
`else
    assign restart = 1'b0;
    assign dc_last = DW'(DIV - 1);
    assign dc_half = DW'(DIV / 2);
    assign fast    = 1'b0;
`endif

    always_comb begin
        dc_nxt = (dc == dc_last) ? '0 : dc + DW'(1);
        if (restart) begin
            dc_nxt = '0;
        end
    end

    // pulse and tick are decoded from the next count so they stay registered and glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc    <= '0;
            pulse <= 1'b0;
            tick  <= 1'b0;
        end else begin
            dc    <= dc_nxt;
            pulse <= !restart && (dc_nxt >= dc_half);
            tick  <= !restart && (dc_nxt == dc_half);
        end
    end

endmodule

// File: tb/tb_clk_btn_conditioner.sv
// Directed self-checking bench for clk_btn_conditioner with DIV=16, DB_CYC=4.
// Define FAST_SET_EN to also exercise the fast-set mode.
module tb_clk_btn_conditioner;

    localparam int DIV    = 16;
    localparam int DB_CYC = 4;
    localparam int NB     = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_clean;
    logic [NB-1:0] btn_rise;
    logic          pulse;
    logic          tick;
    logic          fast;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    clk_btn_conditioner #(
        .DIV    (DIV),
        .DB_CYC (DB_CYC),
        .NB     (NB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean),
        .btn_rise  (btn_rise),
        .pulse     (pulse),
        .tick      (tick),
        .fast      (fast)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        btn_raw = '1;
        repeat (3) next_cycle();
        tests_run++;
        if (btn_clean !== 6'b0 || btn_rise !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_btn clean=%b rise=%b expected 0", btn_clean, btn_rise);
        end
        tests_run++;
        if (pulse !== 1'b0 || tick !== 1'b0 || fast !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_div pulse=%b tick=%b fast=%b expected 0", pulse, tick, fast);
        end
        btn_raw = '0;
    endtask

    task automatic test_divider();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 32; n++) begin
            if (n > 0) next_cycle();
            tests_run++;
            if (pulse !== ((n % 16) >= 8) || tick !== ((n % 16) == 8)) begin
                tests_failed++;
                $display("[TB] FAIL divider cycle %0d pulse=%b tick=%b expected %b %b",
                         n, pulse, tick, (n % 16) >= 8, (n % 16) == 8);
            end
            tests_run++;
            if (btn_clean !== 6'b0 || btn_rise !== 6'b0 || fast !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL divider_btn cycle %0d clean=%b rise=%b fast=%b expected 0",
                         n, btn_clean, btn_rise, fast);
            end
        end
    endtask

    task automatic test_debounce_rise();
        logic [NB-1:0] exp_c;
        logic [NB-1:0] exp_r;
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            exp_c = (k >= 6) ? 6'b000100 : 6'b0;
            exp_r = (k == 6) ? 6'b000100 : 6'b0;
            tests_run++;
            if (btn_clean !== exp_c || btn_rise !== exp_r) begin
                tests_failed++;
                $display("[TB] FAIL debounce_up k=%0d clean=%b rise=%b expected %b %b",
                         k, btn_clean, btn_rise, exp_c, exp_r);
            end
        end
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            exp_c = (k < 6) ? 6'b000100 : 6'b0;
            tests_run++;
            if (btn_clean !== exp_c || btn_rise !== 6'b0) begin
                tests_failed++;
                $display("[TB] FAIL debounce_down k=%0d clean=%b rise=%b expected %b 000000",
                         k, btn_clean, btn_rise, exp_c);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq;
        int rises;
        seq   = 8'b1111_0111;
        rises = 0;
        for (int k = 0; k < 14; k++) begin
            btn_raw[3] = (k < 8) ? seq[k] : 1'b1;
            next_cycle();
            if (btn_rise[3]) rises++;
            tests_run++;
            if (btn_clean[3] !== (k + 1 >= 10) || btn_rise[3] !== (k + 1 == 10)) begin
                tests_failed++;
                $display("[TB] FAIL bounce cycle %0d clean3=%b rise3=%b expected %b %b",
                         k + 1, btn_clean[3], btn_rise[3], k + 1 >= 10, k + 1 == 10);
            end
        end
        tests_run++;
        if (rises != 1) begin
            tests_failed++;
            $display("[TB] FAIL bounce_rise_count got %0d expected 1", rises);
        end
    endtask

    task automatic test_reset_mid_period();
        logic found;
        btn_raw = '0;
        repeat (8) next_cycle();
        btn_raw = 6'b000011;
        repeat (8) next_cycle();
        tests_run++;
        if (btn_clean !== 6'b000011) begin
            tests_failed++;
            $display("[TB] FAIL mid_setup clean=%b expected 000011", btn_clean);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tick) found = 1'b1;
            else next_cycle();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL mid_tick_wait no tick within 20 cycles, expected one");
        end
        repeat (3) next_cycle();
        tests_run++;
        if (pulse !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_dc11_pulse got %b expected 1", pulse);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (btn_clean !== 6'b0 || btn_rise !== 6'b0 || pulse !== 1'b0 || tick !== 1'b0 || fast !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset clean=%b rise=%b pulse=%b tick=%b fast=%b expected all 0",
                     btn_clean, btn_rise, pulse, tick, fast);
        end
        btn_raw = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            next_cycle();
            tests_run++;
            if (tick !== (n == 8) || pulse !== (n >= 8)) begin
                tests_failed++;
                $display("[TB] FAIL post_reset cycle %0d tick=%b pulse=%b expected %b %b",
                         n, tick, pulse, n == 8, n >= 8);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [NB-1:0] exp_c;
        logic [NB-1:0] exp_r;
        btn_raw = 6'b100001;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            exp_c = (k >= 6) ? 6'b100001 : 6'b0;
            exp_r = (k == 6) ? 6'b100001 : 6'b0;
            tests_run++;
            if (btn_clean !== exp_c || btn_rise !== exp_r) begin
                tests_failed++;
                $display("[TB] FAIL simultaneous k=%0d clean=%b rise=%b expected %b %b",
                         k, btn_clean, btn_rise, exp_c, exp_r);
            end
        end
    endtask

`ifdef FAST_SET_EN
    task automatic test_fast_set();
        logic found;
        btn_raw = 6'b100101;
        repeat (6) next_cycle();
        tests_run++;
        if (btn_clean[2] !== 1'b1 || fast !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fast_setup clean2=%b fast=%b expected 1 0", btn_clean[2], fast);
        end
        // First and second ticks with the set condition held.
        for (int t = 0; t < 2; t++) begin
            if (t == 1) next_cycle();
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (tick) found = 1'b1;
                else next_cycle();
            end
            tests_run++;
            if (!found || fast !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL fast_tick%0d found=%b fast=%b expected 1 0", t + 1, found, fast);
            end
        end
        next_cycle();
        tests_run++;
        if (fast !== 1'b1 || pulse !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fast_enter fast=%b pulse=%b expected 1 0", fast, pulse);
        end
        for (int j = 1; j <= 4; j++) begin
            next_cycle();
            tests_run++;
            if (pulse !== (j % 2 == 1) || tick !== (j % 2 == 1)) begin
                tests_failed++;
                $display("[TB] FAIL fast_period j=%0d pulse=%b tick=%b expected %b %b",
                         j, pulse, tick, j % 2 == 1, j % 2 == 1);
            end
        end
        btn_raw = 6'b100001;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            tests_run++;
            if (k < 6 && fast !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL fast_hold k=%0d fast=%b expected 1", k, fast);
            end else if (k == 6 && (fast !== 1'b0 || pulse !== 1'b0 || btn_clean !== 6'b100001)) begin
                tests_failed++;
                $display("[TB] FAIL fast_leave fast=%b pulse=%b clean=%b expected 0 0 100001",
                         fast, pulse, btn_clean);
            end
        end
        for (int n = 1; n <= 9; n++) begin
            next_cycle();
            tests_run++;
            if (tick !== (n == 8) || pulse !== (n >= 8)) begin
                tests_failed++;
                $display("[TB] FAIL fast_resume cycle %0d tick=%b pulse=%b expected %b %b",
                         n, tick, pulse, n == 8, n >= 8);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_divider();
        test_debounce_rise();
        test_bounce();
        test_reset_mid_period();
        test_simultaneous();
`ifdef FAST_SET_EN
        test_fast_set();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
